// File: rtl/adder_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_sched_pkg
// Description : Shared widths, types and the three-operand add helper for
//               the adder scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_sched_pkg;

  localparam int OPERAND_W  = 8;
  localparam int SUM_FULL_W = 10;

  typedef logic [OPERAND_W-1:0]  operand_t;
  typedef logic [SUM_FULL_W-1:0] sum_full_t;

  // Full-precision sum; 10 bits hold 3 * 255 without loss.
  function automatic sum_full_t add3(input operand_t a, input operand_t b,
                                     input operand_t c);
    return sum_full_t'(a) + sum_full_t'(b) + sum_full_t'(c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Searches upward from the pointer with
//               wrap-around; the pointer moves past the winner only when a
//               grant is actually issued (enable high and a request present).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx
);

  logic [ID_W-1:0] r_rr;
  logic [ID_W-1:0] w_idx;
  logic            w_found;
  int              w_k;

  // First asserted request at or above the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = (int'(r_rr) + i) % NUM_REQ;
      if (!w_found && i_req[w_k]) begin
        w_found = 1'b1;
        w_idx   = ID_W'(w_k);
      end
    end
  end

  assign o_grant_idx = w_idx;

  // One-hot grant, suppressed entirely while the pipeline cannot advance.
  always_comb begin
    o_grant = '0;
    if (i_en && w_found) begin
      o_grant[w_idx] = 1'b1;
    end
  end

  // Pointer moves to the index just past the winner on every issued grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr <= '0;
    end else if (i_en && w_found) begin
      r_rr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adder_scheduler
// Description : Shares one two-stage registered three-operand 8-bit adder
//               among NUM_REQ requesters. Round-robin issue, ID-tagged
//               results, global stall on result backpressure.
//               Build option: define ADDER_SCHED_SAT_EN to clamp sums above
//               255 to 8'hFF instead of wrapping modulo 256.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*OPERAND_W-1:0] i_req_a,
  input  logic [NUM_REQ*OPERAND_W-1:0] i_req_b,
  input  logic [NUM_REQ*OPERAND_W-1:0] i_req_c,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_res_valid,
  output logic [OPERAND_W-1:0]       o_res_sum,
  output logic [ID_W-1:0]            o_res_id,
  input  logic                       i_res_ready
);

  logic               w_advance;
  logic               w_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_accept;
  operand_t           w_a;
  operand_t           w_b;
  operand_t           w_c;
  sum_full_t          w_sum_full;
  operand_t           w_sum_out;

  logic               r_s1_valid;
  operand_t           r_s1_a;
  operand_t           r_s1_b;
  operand_t           r_s1_c;
  logic [ID_W-1:0]    r_s1_id;

  // The whole pipeline moves together; a held result freezes both stages.
  assign w_advance = !o_res_valid || i_res_ready;
  // Reset also masks grants so ready is low for the full reset window.
  assign w_en      = w_advance && !i_rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req_valid),
    .i_en        (w_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign o_req_ready = w_grant;
  assign w_accept    = |w_grant;

  // Operand mux: pick the granted requester's lane from each packed bus.
  assign w_a = i_req_a[int'(w_grant_idx)*OPERAND_W +: OPERAND_W];
  assign w_b = i_req_b[int'(w_grant_idx)*OPERAND_W +: OPERAND_W];
  assign w_c = i_req_c[int'(w_grant_idx)*OPERAND_W +: OPERAND_W];

  // Stage 1: capture the granted triple and its ID; a bubble when no grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
      r_s1_id    <= '0;
    end else if (w_advance) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a  <= w_a;
        r_s1_b  <= w_b;
        r_s1_c  <= w_c;
        r_s1_id <= w_grant_idx;
      end
    end
  end

  assign w_sum_full = add3(r_s1_a, r_s1_b, r_s1_c);

`ifdef ADDER_SCHED_SAT_EN
  // Any carry into bits 9:8 means the true sum exceeds 255.
  assign w_sum_out = (w_sum_full[SUM_FULL_W-1:OPERAND_W] != '0) ? '1
                                                                : w_sum_full[OPERAND_W-1:0];
`else
  assign w_sum_out = w_sum_full[OPERAND_W-1:0];
`endif

  // Stage 2: register the sum, tag and valid for the result port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_res_valid <= 1'b0;
      o_res_sum   <= '0;
      o_res_id    <= '0;
    end else if (w_advance) begin
      o_res_valid <= r_s1_valid;
      o_res_sum   <= w_sum_out;
      o_res_id    <= r_s1_id;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_scheduler
// Description : Directed scoreboard bench for adder_scheduler (NUM_REQ=4).
//               Stimulus pushes expected {id,sum} on each predicted grant;
//               a monitor pops and compares on every consumed result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ*8-1:0] req_c;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic [7:0]           res_sum;
  logic [ID_W-1:0]      res_id;
  logic                 res_ready;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      sum;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  adder_scheduler #(
    .NUM_REQ (NUM_REQ)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_c     (req_c),
    .o_req_ready (req_ready),
    .o_res_valid (res_valid),
    .o_res_sum   (res_sum),
    .o_res_id    (res_id),
    .i_res_ready (res_ready)
  );

  // Reference result for one triple.
  function automatic logic [7:0] model_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    logic [9:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c};
`ifdef ADDER_SCHED_SAT_EN
    return (s > 10'd255) ? 8'hFF : s[7:0];
`else
    return s[7:0];
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c);
    req_valid[n]      = v;
    req_a[n*8 +: 8]   = a;
    req_b[n*8 +: 8]   = b;
    req_c[n*8 +: 8]   = c;
  endtask

  // One cycle: check grant (and optionally result valid) at the falling
  // edge, book the expected result for the predicted winner, then advance.
  task automatic tick(input logic [NUM_REQ-1:0] exp_rdy, input int exp_rv,
                      input string tag);
    exp_t e;
    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'(exp_rdy));
    if (exp_rv >= 0) chk({tag, " res_valid"}, 32'(res_valid), 32'(exp_rv));
    for (int n = 0; n < NUM_REQ; n++) begin
      if (exp_rdy[n]) begin
        e.id  = ID_W'(n);
        e.sum = model_sum(req_a[n*8 +: 8], req_b[n*8 +: 8], req_c[n*8 +: 8]);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({tag, " drain"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every consumed result must match the oldest booked entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected result: got id=%0d sum=%0h expected none", res_id, res_sum);
      end else begin
        e = sb.pop_front();
        chk("result id", 32'(res_id), 32'(e.id));
        chk("result sum", 32'(res_sum), 32'(e.sum));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    res_ready = 1'b1;
    set_req(1, 1'b1, 8'd1, 8'd1, 8'd1);

    // Reset state, with a request present: no grant may appear.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset sum", 32'(res_sum), 32'd0);
    chk("reset id", 32'(res_id), 32'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b0;

    // Single request from 2: 10+20+30=60, two-cycle latency.
    set_req(2, 1'b1, 8'd10, 8'd20, 8'd30);
    tick(4'b0100, 0, "single issue");
    req_valid = '0;
    tick(4'b0000, 0, "single s1");
    tick(4'b0000, 1, "single out");
    tick(4'b0000, 0, "single after");
    drain("single");

    // Full contention; pointer sits at 3 after the single grant to 2.
    set_req(0, 1'b1, 8'd1,   8'd2,   8'd3);
    set_req(1, 1'b1, 8'd100, 8'd100, 8'd50);
    set_req(2, 1'b1, 8'd255, 8'd1,   8'd0);
    set_req(3, 1'b1, 8'd7,   8'd8,   8'd9);
    tick(4'b1000, -1, "rr g3");
    tick(4'b0001, -1, "rr g0");
    tick(4'b0010, -1, "rr g1");
    tick(4'b0100, 1,  "rr g2");
    tick(4'b1000, 1,  "rr g3b");
    tick(4'b0001, 1,  "rr g0b");
    req_valid = '0;
    drain("contention");

    // Overflow: 200*3 = 600 -> 0x58 wrapped, 0xFF saturated.
    set_req(1, 1'b1, 8'd200, 8'd200, 8'd200);
    tick(4'b0010, -1, "ovf issue");
    req_valid = '0;
    drain("overflow");

    // Backpressure: result 1+2+3 from requester 0 held for 3 cycles.
    set_req(0, 1'b1, 8'd1, 8'd2, 8'd3);
    tick(4'b0001, -1, "bp issue");
    req_valid = '0;
    tick(4'b0000, 0, "bp s1");
    res_ready = 1'b0;
    set_req(1, 1'b1, 8'd5, 8'd5, 8'd5);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, 1, "bp stall");
      chk("bp stall sum", 32'(res_sum), 32'h06);
      chk("bp stall id", 32'(res_id), 32'd0);
    end
    res_ready = 1'b1;
    tick(4'b0010, 1, "bp release");
    req_valid = '0;
    drain("backpressure");

    // Reset mid-stream with both stages occupied; pointer sits at 2.
    set_req(0, 1'b1, 8'd1, 8'd1, 8'd1);
    set_req(1, 1'b1, 8'd4, 8'd4, 8'd4);
    set_req(2, 1'b1, 8'd9, 8'd9, 8'd9);
    set_req(3, 1'b1, 8'd3, 8'd3, 8'd3);
    tick(4'b0100, -1, "mid g2");
    tick(4'b1000, -1, "mid g3");
    rst = 1'b1;
    sb.delete();
    req_valid[0] = 1'b0;
    req_valid[3] = 1'b0;
    #1;
    chk("mid rst res_valid", 32'(res_valid), 32'd0);
    chk("mid rst ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4'b0010, -1, "post rst g1");
    tick(4'b0100, -1, "post rst g2");
    req_valid = '0;
    drain("midreset");

    // Fairness: requester 0 holds valid, requester 3 pulses in.
    set_req(0, 1'b1, 8'd11, 8'd22, 8'd33);
    set_req(3, 1'b0, 8'd40, 8'd50, 8'd60);
    tick(4'b0001, -1, "fair g0");
    tick(4'b0001, -1, "fair g0b");
    req_valid[3] = 1'b1;
    tick(4'b1000, -1, "fair g3");
    tick(4'b0001, -1, "fair g0c");
    req_valid[3] = 1'b0;
    tick(4'b0001, -1, "fair g0d");
    req_valid = '0;
    drain("fairness");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_scheduler.md
# adder_scheduler

Shares one registered three-operand 8-bit adder pipeline among `NUM_REQ` requesters. Each requester offers an operand triple with a valid/ready handshake. A round-robin arbiter issues at most one triple per cycle into a two-stage pipeline: operand register, then sum register. Each result returns on a single result port, tagged with the requester ID, and obeys result-side backpressure.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `ID_W`, localparam, `$clog2(NUM_REQ)`: requester tag width.

Ports:
- `i_clk`, input, 1: single clock; all logic is clocked on its rising edge.
- `i_rst`, input, 1: reset, asynchronous, active-high.
- `i_req_valid`, input, `NUM_REQ`: per-requester operand valid.
- `i_req_a`, input, `NUM_REQ*8`: operand A. Requester n occupies bits `[8n+7:8n]`.
- `i_req_b`, input, `NUM_REQ*8`: operand B, same packing as A.
- `i_req_c`, input, `NUM_REQ*8`: operand C, same packing as A.
- `o_req_ready`, output, `NUM_REQ`: one-hot grant. At most one bit is high.
- `o_res_valid`, output, 1: result valid.
- `o_res_sum`, output, 8: result sum.
- `o_res_id`, output, `ID_W`: index of the requester that issued the result.
- `i_res_ready`, input, 1: result consumer ready.

## Operation
- `advance = !o_res_valid || i_res_ready`.
- Grant selection:
  - The arbiter picks the first asserted `i_req_valid` bit, searching upward from pointer `rr_q` with wrap-around.
  - `o_req_ready[g] = advance && i_req_valid[g]` for the granted index g only.
  - `o_req_ready` is combinational. It never depends on ready of another requester.
- Accept: when `i_req_valid[g] && o_req_ready[g]` at a rising edge:
  - stage 1 captures A, B and C of requester g, plus ID g;
  - stage-1 valid is set;
  - `rr_q` becomes `(g+1) mod NUM_REQ`.
- When nothing is granted, `rr_q` holds and stage-1 valid clears, provided `advance` is true.
- Stage 2 (when `advance` is true) computes the 10-bit sum A+B+C of the stage-1 operands. It registers:
  - `o_res_sum` = the low 8 bits of that sum (modulo 256);
  - `o_res_id` = the stage-1 ID;
  - `o_res_valid` = the stage-1 valid.
- Stall: when `o_res_valid && !i_res_ready`, both stages hold, and every `o_req_ready` bit is 0. The stall is global; stage-1 bubbles are not squeezed out.
- Results leave in issue order. There is no reordering and no drop.
- Reset, asynchronous at any time:
  - all valids clear, `rr_q` goes to 0, and data/ID registers go to 0;
  - in-flight results are discarded;
  - `o_req_ready` is 0 while `i_rst` is high.
- Every output reset value is 0.

## Timing
- Latency: a triple accepted at edge k produces `o_res_valid` high in the cycle following edge k+1, i.e. 2 cycles, provided there is no stall.
- Throughput: one triple per cycle while `i_res_ready` is held high.
- Each cycle of `i_res_ready` low while `o_res_valid` is high adds one cycle of latency to every in-flight item.
- A requester whose valid stays high under continuous contention from all requesters is granted within `NUM_REQ` accepting cycles.
- Simultaneous events:
  - A result is consumed and a new triple is accepted on the same edge; this is legal and loses no cycle.
  - A requester dropping `i_req_valid` without a handshake is allowed. The arbiter re-evaluates combinationally in the same cycle.

## Configuration
- Macro `ADDER_SCHED_SAT_EN`.
- Defined: stage 2 clamps the sum. If the 10-bit sum exceeds 255, `o_res_sum` is 8'hFF.
- Undefined: `o_res_sum` wraps modulo 256.
- Latency, handshakes and ID handling are identical in both builds.

## Structure
- Package `adder_sched_pkg` holds:
  - `OPERAND_W` = 8;
  - `SUM_FULL_W` = 10;
  - typedef `operand_t` (`logic [OPERAND_W-1:0]`);
  - typedef `sum_full_t`.
- Sub-module `rr_arbiter`:
  - parameter `NUM_REQ`;
  - inputs: request vector, enable (`advance`);
  - outputs: one-hot grant and encoded grant index;
  - owns the `rr_q` pointer, with asynchronous reset to 0.
- The top level holds the operand mux, the pipeline registers and the sum/saturation logic.

## Test plan
- Single request: requester 2 sends A=10, B=20, C=30 with `i_res_ready`=1 → one-cycle ready pulse on bit 2; two cycles later `o_res_valid`=1, sum=60, id=2.
- Full contention: all 4 requesters hold valid, `i_res_ready`=1 → grants 0,1,2,3,0,… once per cycle; results return with ids in the same order, back-to-back.
- Overflow: A=B=C=200 → sum 0x58 (600 mod 256) without `ADDER_SCHED_SAT_EN`; 0xFF with it.
- Backpressure: `i_res_ready`=0 for 3 cycles with a result pending → `o_res_valid`, sum and id stable; `o_req_ready`=0 throughout; no result lost or duplicated after release.
- Reset mid-stream: assert `i_rst` with both stages valid → `o_res_valid` and `o_req_ready` go to 0 immediately; after release, the next grant goes to the lowest valid index from pointer 0.
- Fairness: requester 0 holds valid continuously while requester 3 pulses valid → requester 3 is granted within 4 cycles of asserting.
